// File: rtl/demux_rr_sched_pkg.sv
// Shared constants and types for the round-robin demux scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_rr_sched_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Next channel index in circular order, 3 wraps to 0.
    function automatic logic [SEL_W-1:0] sel_inc(input logic [SEL_W-1:0] s);
        return s + 1'b1;
    endfunction

endpackage

// File: rtl/demux_rr_sched_if.sv
// Producer/consumer handshake and demux control bundle for demux_rr_sched.
// Latency: n/a (wires only).
// Backpressure: in_ready toward the producer, out_ready[sel] from the consumers.
interface demux_rr_sched_if #(
    parameter int DW = 8
);
    import demux_rr_sched_pkg::*;

    logic             in_valid;
    logic [DW-1:0]    in_data;
    logic             in_ready;
    logic [NCH-1:0]   ch_en;
    logic [NCH-1:0]   out_ready;
    logic             out_valid;
    logic [SEL_W-1:0] sel;
    logic [DW-1:0]    out_data;
    logic             busy;

    // Environment side: producer, consumers and channel enable source.
    modport master (
        output in_valid, in_data, ch_en, out_ready,
        input  in_ready, out_valid, sel, out_data, busy
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_data, ch_en, out_ready,
        output in_ready, out_valid, sel, out_data, busy
    );

endinterface

// File: rtl/demux_rr_sched_rr_pick.sv
// Circular first-set-bit finder: lowest enabled channel at or after start.
// Latency: purely combinational.
// Backpressure: none; any=0 tells the caller there is no eligible channel.
module rr_pick
    import demux_rr_sched_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             any
);

    logic [SEL_W-1:0] pos;

    // Scan offsets from farthest to nearest so the nearest enabled channel wins.
    always_comb begin
        idx = '0;
        pos = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            pos = start + SEL_W'(i);
            if (mask[pos]) begin
                idx = pos;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/demux_rr_sched.sv
// Single-slot round-robin scheduler driving a 1-to-4 demux select; optional counters via DEMUX_RR_SCHED_CNT_EN.
// Latency: item accepted at edge N is presented from edge N; 1 item/cycle sustained.
// Backpressure: in_ready only when a channel is enabled and the slot is empty or draining this cycle.
module demux_rr_sched
    import demux_rr_sched_pkg::*;
#(
    parameter int DW    = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
`ifdef DEMUX_RR_SCHED_CNT_EN
    input  logic                 cnt_clr,
    output logic [NCH*CNT_W-1:0] ch_cnt,
`endif
    demux_rr_sched_if.slave      bus
);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [DW-1:0]    data_q, data_d;

    logic             xfer;
    logic             acc;
    logic             in_ready;
    logic [SEL_W-1:0] pick_start;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;

    // A held item leaves only through its locked channel; other ready bits are ignored.
    assign xfer = (state_q == ST_HOLD) && bus.out_ready[sel_q];

    // Refill in the same cycle the slot drains, so back-to-back items flow at full rate.
    assign in_ready = pick_any && ((state_q == ST_EMPTY) || xfer);
    assign acc      = bus.in_valid && in_ready;

    // Acceptance while holding implies a transfer, so resume just past the departing channel.
    assign pick_start = (state_q == ST_HOLD) ? sel_inc(sel_q) : ptr_q;

    rr_pick u_pick (
        .mask  (bus.ch_en),
        .start (pick_start),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // Next-state: load on accept, drop to EMPTY on a bare transfer, advance pointer on transfer.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ptr_d   = ptr_q;
        if (acc) begin
            state_d = ST_HOLD;
            sel_d   = pick_idx;
            data_d  = bus.in_data;
        end else if (xfer) begin
            state_d = ST_EMPTY;
        end
        if (xfer) begin
            ptr_d = sel_inc(sel_q);
        end
    end

    // State and datapath registers; reset discards any held item.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            sel_q   <= '0;
            data_q  <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q == ST_HOLD);
    assign bus.sel       = sel_q;
    assign bus.out_data  = data_q;

`ifdef DEMUX_RR_SCHED_CNT_EN
    logic [CNT_W-1:0] cnt_q [NCH];
    logic [CNT_W-1:0] cnt_d [NCH];

    // Count deliveries per channel; clear beats a coincident increment.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_d[i] = cnt_q[i];
        end
        if (cnt_clr) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_d[i] = '0;
            end
        end else if (xfer) begin
            cnt_d[sel_q] = cnt_q[sel_q] + 1'b1;
        end
    end

    // Counter registers, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Flatten counters onto the output bus, channel i at slice i.
    always_comb begin
        ch_cnt = '0;
        for (int i = 0; i < NCH; i++) begin
            ch_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_demux_rr_sched.sv
module tb_demux_rr_sched;
    import demux_rr_sched_pkg::*;

`ifdef DEMUX_RR_SCHED_CNT_EN
    localparam int TB_CNT_W = 2;
`else
    localparam int TB_CNT_W = 8;
`endif

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    demux_rr_sched_if #(.DW(8)) bus ();

`ifdef DEMUX_RR_SCHED_CNT_EN
    logic                    cnt_clr;
    logic [4*TB_CNT_W-1:0]   ch_cnt;
`endif

    demux_rr_sched #(.DW(8), .CNT_W(TB_CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
`ifdef DEMUX_RR_SCHED_CNT_EN
        .cnt_clr (cnt_clr),
        .ch_cnt  (ch_cnt),
`endif
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.ch_en = 4'b1111;
        bus.out_ready = 4'b1111;
        #12;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.sel !== 2'd0) begin bad++; $display("FAIL reset_sel got=%0d exp=0", bus.sel); end
        total++; if (bus.out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", bus.out_data); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        logic [1:0] s;
        bus.ch_en = 4'b1111;
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            d = 8'h10 + 8'(k);
            s = 2'(k);
            bus.in_valid = 1'b1;
            bus.in_data = d;
            #1;
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready k=%0d got=%b exp=1", k, bus.in_ready); end
            tick();
            total++; if (bus.out_valid !== 1'b1 || bus.sel !== s || bus.out_data !== d) begin
                bad++; $display("FAIL b2b_item k=%0d got vld=%b sel=%0d dat=%h exp vld=1 sel=%0d dat=%h", k, bus.out_valid, bus.sel, bus.out_data, s, d);
            end
        end
        bus.in_valid = 1'b0;
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got vld=%b busy=%b exp 0 0", bus.out_valid, bus.busy); end
    endtask

    task automatic test_sparse_mask();
        logic [1:0] exp_sel [4];
        exp_sel[0] = 2'd0; exp_sel[1] = 2'd2; exp_sel[2] = 2'd0; exp_sel[3] = 2'd2;
        do_reset();
        bus.ch_en = 4'b0101;
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'hA0 + 8'(k);
            tick();
            total++; if (bus.sel !== exp_sel[k] || bus.out_data !== 8'hA0 + 8'(k)) begin
                bad++; $display("FAIL sparse_item k=%0d got sel=%0d dat=%h exp sel=%0d dat=%h", k, bus.sel, bus.out_data, exp_sel[k], 8'hA0 + 8'(k));
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_stall();
        do_reset();
        bus.ch_en = 4'b1111;
        bus.out_ready = 4'b1111;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h01;
        tick();
        bus.in_valid = 1'b0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data = 8'h55;
        tick();
        total++; if (bus.sel !== 2'd1 || bus.out_data !== 8'h55) begin bad++; $display("FAIL stall_pick got sel=%0d dat=%h exp sel=1 dat=55", bus.sel, bus.out_data); end
        bus.out_ready = 4'b1101;
        bus.in_data = 8'h66;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (bus.out_valid !== 1'b1 || bus.sel !== 2'd1 || bus.out_data !== 8'h55 || bus.in_ready !== 1'b0) begin
                bad++; $display("FAIL stall_hold k=%0d got vld=%b sel=%0d dat=%h rdy=%b exp 1 1 55 0", k, bus.out_valid, bus.sel, bus.out_data, bus.in_ready);
            end
            tick();
        end
        bus.out_ready = 4'b1111;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release_rdy got=%b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.sel !== 2'd2 || bus.out_data !== 8'h66) begin bad++; $display("FAIL stall_next got sel=%0d dat=%h exp sel=2 dat=66", bus.sel, bus.out_data); end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_no_channel();
        do_reset();
        bus.ch_en = 4'b0000;
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h77;
        #1;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL nochan_in_ready got=%b exp=0", bus.in_ready); end
        tick();
        tick();
        total++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL nochan_idle got busy=%b vld=%b exp 0 0", bus.busy, bus.out_valid); end
        bus.ch_en = 4'b1000;
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL nochan_en_rdy got=%b exp=1", bus.in_ready); end
        tick();
        total++; if (bus.sel !== 2'd3 || bus.out_data !== 8'h77 || bus.busy !== 1'b1) begin
            bad++; $display("FAIL nochan_accept got sel=%0d dat=%h busy=%b exp sel=3 dat=77 busy=1", bus.sel, bus.out_data, bus.busy);
        end
        bus.in_valid = 1'b0;
        bus.ch_en = 4'b0000;
        bus.out_ready = 4'b0111;
        tick();
        total++; if (bus.busy !== 1'b1 || bus.sel !== 2'd3) begin bad++; $display("FAIL nochan_locked got busy=%b sel=%0d exp busy=1 sel=3", bus.busy, bus.sel); end
        bus.out_ready = 4'b1000;
        tick();
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL nochan_drain got busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        bus.ch_en = 4'b0100;
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h88;
        tick();
        bus.in_valid = 1'b0;
        total++; if (bus.sel !== 2'd2 || bus.busy !== 1'b1) begin bad++; $display("FAIL midrst_pre got sel=%0d busy=%b exp sel=2 busy=1", bus.sel, bus.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.sel !== 2'd0) begin
            bad++; $display("FAIL midrst_async got vld=%b busy=%b sel=%0d exp 0 0 0", bus.out_valid, bus.busy, bus.sel);
        end
        #1;
        rst_n = 1'b1;
        bus.ch_en = 4'b1111;
        bus.out_ready = 4'b1111;
        bus.in_valid = 1'b1;
        bus.in_data = 8'h99;
        tick();
        total++; if (bus.sel !== 2'd0 || bus.out_data !== 8'h99) begin bad++; $display("FAIL midrst_after got sel=%0d dat=%h exp sel=0 dat=99", bus.sel, bus.out_data); end
        bus.in_valid = 1'b0;
        tick();
    endtask

`ifdef DEMUX_RR_SCHED_CNT_EN
    task automatic test_counters();
        cnt_clr = 1'b0;
        do_reset();
        bus.ch_en = 4'b0001;
        bus.out_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data = 8'(k);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        total++; if (ch_cnt !== 8'b00_00_00_01) begin bad++; $display("FAIL cnt_wrap got=%b exp=00000001", ch_cnt); end
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.out_ready = 4'b1111;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        total++; if (ch_cnt !== 8'h00 || bus.busy !== 1'b0) begin bad++; $display("FAIL cnt_clr_wins got cnt=%b busy=%b exp cnt=0 busy=0", ch_cnt, bus.busy); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
`ifdef DEMUX_RR_SCHED_CNT_EN
        cnt_clr = 1'b0;
`endif
        test_reset();
        test_back_to_back();
        test_sparse_mask();
        test_stall();
        test_no_channel();
        test_reset_mid_hold();
`ifdef DEMUX_RR_SCHED_CNT_EN
        test_counters();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_rr_sched.md
Name: demux_rr_sched

Overview:
- Round-robin scheduler that sequences the team's 1-to-4 demultiplexer: data A, selects S0/S1, outputs O1..O4.
- Accepts a single valid/ready input stream, holds one item, picks the next enabled destination channel in round-robin order, and drives the demux select plus a per-channel valid/ready handshake.
- Sits between a single producer and four consumers. out_valid gates the demux A input; sel drives {S1,S0}.

Parameters:
- DW, 8, data width of in_data/out_data.
- CNT_W, 8, width of each per-channel delivery counter (used only with the optional feature).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer has an item.
- in_data  input  DW  producer item.
- in_ready  output  1  scheduler accepts the item this cycle.
- ch_en  input  4  per-channel enable mask; bit i = channel i (O(i+1)).
- out_ready  input  4  per-channel consumer ready.
- out_valid  output  1  held item is presented; drives demux A.
- sel  output  2  target channel; sel[0]=S0, sel[1]=S1 (0→O1, 1→O2, 2→O3, 3→O4).
- out_data  output  DW  held item.
- busy  output  1  holding register occupied.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, sel=0, out_data=0, busy=0, round-robin pointer ptr=0. Any held item is discarded.
- State machine, two states:
  - EMPTY: busy=0, out_valid=0.
  - HOLD: busy=1, out_valid=1.
- Transfer: xfer = out_valid & out_ready[sel].
- Accept: acc = in_valid & in_ready.
- in_ready = |ch_en & (EMPTY | xfer). Combinational; the scheduler takes a new item in the same cycle the held one leaves.
- Target pick on acc: first i with ch_en[i]=1, searching circularly from start.
  - start = ptr in EMPTY; start = (sel+1) mod 4 when acc coincides with xfer.
- On acc (edge): out_data←in_data, sel←picked i, state→HOLD.
- On xfer without acc: state→EMPTY. sel and out_data hold their last values.
- On xfer: ptr←(sel+1) mod 4, wrapping 3→0.
- Latency: item accepted at edge N appears on out_valid/sel/out_data after edge N. Sustained throughput is 1 item/cycle when the targets are ready.
- sel and out_data stay stable while out_valid=1 and not xfer. The handshake may not be withdrawn.
- ch_en[sel] deasserted while in HOLD: the item is still delivered to the locked sel. ch_en changes affect only the next pick.
- ch_en=0000: in_ready=0. A held item still drains.
- out_ready bits other than out_ready[sel] are ignored.
- in_valid with no enabled channel: no accept, no state change.

Optional Feature:
- Macro: DEMUX_RR_SCHED_CNT_EN.
- Defined:
  - adds input cnt_clr (1) and output ch_cnt (4*CNT_W); channel i occupies ch_cnt[i*CNT_W +: CNT_W].
  - counter i increments on xfer with sel=i and wraps modulo 2^CNT_W.
  - cnt_clr is synchronous and zeroes all counters; it wins over a simultaneous increment.
  - reset zeroes all counters.
- Not defined: cnt_clr, ch_cnt and all counter logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package demux_rr_sched_pkg:
  - NCH=4, SEL_W=2.
  - state encoding ST_EMPTY=1'b0, ST_HOLD=1'b1.
- One sub-module, rr_pick: combinational.
  - inputs: mask[4], start[2].
  - outputs: idx[2] (first set bit at or after start, circular), any (1 if mask nonzero).

Test Plan:
- Reset release, ch_en=1111, all out_ready=1, 8 back-to-back items 0x10..0x17 → sel sequence 0,1,2,3,0,1,2,3; one item per cycle; out_data matches in order.
- ch_en=0101, all ready, items 0xA0..0xA3 → sel 0,2,0,2; channels 1 and 3 never selected.
- ch_en=1111, item 0x55 accepted, sel=1, out_ready[1]=0 for 5 cycles → out_valid, sel and out_data stable; in_ready=0; on out_ready[1]=1 one xfer occurs, next item goes to sel=2.
- ch_en=0000 with in_valid=1 → in_ready=0, busy=0. Then ch_en=1000 → item accepted, sel=3.
- Item held on sel=2, rst_n pulsed low mid-hold → out_valid=0, busy=0, sel=0 immediately. First item after release goes to sel=0.
- With DEMUX_RR_SCHED_CNT_EN, CNT_W=2, 5 items all to ch_en=0001 → ch_cnt[1:0]=1 (wrap). cnt_clr asserted on the same cycle as an xfer → counter reads 0 afterwards.
